// File: rtl/bus_err_drain_arb.sv
// bus_err_drain_arb
// Round-robin drain controller for several bus error units. It pops one error
// record at a time from the unit FIFOs, tags it with the source index and
// presents it on a single valid/ready report stream. It also keeps a saturating
// counter per unit of how often that unit's FIFO became full.
module bus_err_drain_arb #(
  parameter int unsigned NumUnits      = 32'd4,
  parameter int unsigned AddrWidth     = 32'd48,
  parameter int unsigned MetaDataWidth = 32'd1,
  parameter int unsigned ErrBits       = 32'd3,
  parameter int unsigned CntWidth      = 32'd8,
  localparam int unsigned IdxWidth     = (NumUnits > 32'd1) ? $clog2(NumUnits) : 32'd1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               enable_i,
  input  logic [NumUnits-1:0]                src_mask_i,
  input  logic [NumUnits-1:0]                unit_err_irq_i,
  input  logic [NumUnits*ErrBits-1:0]        unit_err_code_i,
  input  logic [NumUnits*AddrWidth-1:0]      unit_err_addr_i,
  input  logic [NumUnits*MetaDataWidth-1:0]  unit_err_meta_i,
  input  logic [NumUnits-1:0]                unit_ovf_i,
  output logic [NumUnits-1:0]                unit_pop_o,
  output logic                               rpt_valid_o,
  input  logic                               rpt_ready_i,
  output logic [IdxWidth-1:0]                rpt_src_o,
  output logic [ErrBits-1:0]                 rpt_code_o,
  output logic [AddrWidth-1:0]               rpt_addr_o,
  output logic [MetaDataWidth-1:0]           rpt_meta_o,
  output logic                               rpt_ovf_o,
  output logic                               irq_o,
  output logic [NumUnits*CntWidth-1:0]       ovf_cnt_o,
  input  logic                               ovf_cnt_clr_i
);

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StPend = 1'b1
  } state_e;

  localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

  // Registered state
  state_e                             state_r;
  logic [IdxWidth-1:0]                rr_ptr_r;
  logic                               rpt_valid_r;
  logic [IdxWidth-1:0]                rpt_src_r;
  logic [ErrBits-1:0]                 rpt_code_r;
  logic [AddrWidth-1:0]               rpt_addr_r;
  logic [MetaDataWidth-1:0]           rpt_meta_r;
  logic                               rpt_ovf_r;
  logic [NumUnits-1:0]                ovf_prev_r;
  logic [NumUnits-1:0][CntWidth-1:0]  ovf_cnt_r;

  // Combinational selection signals
  logic [NumUnits-1:0]                eligible_s;
  logic [NumUnits-1:0]                at_or_after_s;
  logic [NumUnits-1:0]                elig_hi_s;
  logic [NumUnits-1:0]                pick_s;
  logic [NumUnits-1:0]                sel_oh_s;
  logic [IdxWidth-1:0]                sel_idx_s;
  logic [IdxWidth-1:0]                ptr_next_s;
  logic [ErrBits-1:0]                 head_code_s;
  logic [AddrWidth-1:0]               head_addr_s;
  logic [MetaDataWidth-1:0]           head_meta_s;
  logic                               head_ovf_s;
  logic                               capture_s;
  logic [NumUnits-1:0]                ovf_rise_s;

  assign eligible_s = unit_err_irq_i & ~src_mask_i;
  assign ovf_rise_s = unit_ovf_i & ~ovf_prev_r;

  // Round-robin pick: lowest eligible unit at or after rr_ptr, else lowest eligible overall (wrap).
  always_comb begin
    at_or_after_s = {NumUnits{1'b0}};
    for (int i = 0; i < int'(NumUnits); i++) begin
      at_or_after_s[i] = (i >= int'(rr_ptr_r));
    end
    elig_hi_s = eligible_s & at_or_after_s;
    pick_s    = (|elig_hi_s) ? elig_hi_s : eligible_s;
    // Isolate the lowest set bit of the candidate vector.
    sel_oh_s  = pick_s & (~pick_s + NumUnits'(1));
  end

  // One-hot to index conversion and AND-OR mux of the selected unit's head-of-FIFO fields.
  always_comb begin
    sel_idx_s   = {IdxWidth{1'b0}};
    head_code_s = {ErrBits{1'b0}};
    head_addr_s = {AddrWidth{1'b0}};
    head_meta_s = {MetaDataWidth{1'b0}};
    head_ovf_s  = 1'b0;
    for (int i = 0; i < int'(NumUnits); i++) begin
      sel_idx_s   = sel_idx_s   | ({IdxWidth{sel_oh_s[i]}} & IdxWidth'(i));
      head_code_s = head_code_s | ({ErrBits{sel_oh_s[i]}} & unit_err_code_i[i*ErrBits +: ErrBits]);
      head_addr_s = head_addr_s | ({AddrWidth{sel_oh_s[i]}} & unit_err_addr_i[i*AddrWidth +: AddrWidth]);
      head_meta_s = head_meta_s |
                    ({MetaDataWidth{sel_oh_s[i]}} & unit_err_meta_i[i*MetaDataWidth +: MetaDataWidth]);
      head_ovf_s  = head_ovf_s  | (sel_oh_s[i] & unit_ovf_i[i]);
    end
  end

  // The pointer moves to the unit just after the one served, so a unit is only
  // picked twice in a row when it is the sole eligible unit.
  assign ptr_next_s = (sel_idx_s == IdxWidth'(NumUnits - 32'd1)) ? {IdxWidth{1'b0}}
                                                                  : sel_idx_s + IdxWidth'(1);

  // A new record is taken when the report slot is free or being freed this cycle.
  // Qualifying with rst_ni keeps a unit from being popped while the controller is
  // held in reset, where the record would otherwise be discarded unseen.
  assign capture_s = rst_ni & enable_i & (|eligible_s) &
                     ((state_r == StIdle) | (rpt_valid_r & rpt_ready_i));

  assign unit_pop_o = {NumUnits{capture_s}} & sel_oh_s;

  // Report FSM: captures the selected head record and holds it until accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= StIdle;
      rr_ptr_r    <= {IdxWidth{1'b0}};
      rpt_valid_r <= 1'b0;
      rpt_src_r   <= {IdxWidth{1'b0}};
      rpt_code_r  <= {ErrBits{1'b0}};
      rpt_addr_r  <= {AddrWidth{1'b0}};
      rpt_meta_r  <= {MetaDataWidth{1'b0}};
      rpt_ovf_r   <= 1'b0;
    end else if (capture_s) begin
      state_r     <= StPend;
      rr_ptr_r    <= ptr_next_s;
      rpt_valid_r <= 1'b1;
      rpt_src_r   <= sel_idx_s;
      rpt_code_r  <= head_code_s;
      rpt_addr_r  <= head_addr_s;
      rpt_meta_r  <= head_meta_s;
      rpt_ovf_r   <= head_ovf_s;
    end else begin
      case (state_r)
        StIdle: begin
          rpt_valid_r <= 1'b0;
        end
        StPend: begin
          if (rpt_ready_i) begin
            state_r     <= StIdle;
            rpt_valid_r <= 1'b0;
          end else begin
            rpt_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= StIdle;
          rpt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Per-unit saturating counters of FIFO-full events (rising edges of unit_ovf_i).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_prev_r <= {NumUnits{1'b0}};
      ovf_cnt_r  <= {(NumUnits*CntWidth){1'b0}};
    end else begin
      ovf_prev_r <= unit_ovf_i;
      if (ovf_cnt_clr_i) begin
        ovf_cnt_r <= {(NumUnits*CntWidth){1'b0}};
      end else begin
        for (int i = 0; i < int'(NumUnits); i++) begin
          if (ovf_rise_s[i] && (ovf_cnt_r[i] != CntMax)) begin
            ovf_cnt_r[i] <= ovf_cnt_r[i] + CntWidth'(1);
          end else begin
            ovf_cnt_r[i] <= ovf_cnt_r[i];
          end
        end
      end
    end
  end

  assign rpt_valid_o = rpt_valid_r;
  assign rpt_src_o   = rpt_src_r;
  assign rpt_code_o  = rpt_code_r;
  assign rpt_addr_o  = rpt_addr_r;
  assign rpt_meta_o  = rpt_meta_r;
  assign rpt_ovf_o   = rpt_ovf_r;
  assign irq_o       = rpt_valid_r;
  assign ovf_cnt_o   = ovf_cnt_r;

endmodule
